// File: rtl/mips_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_core
// Purpose  : Multicycle MIPS core. The datapath and the control FSM live in
//            one block. Memory is reached through a req/ready bus, so the
//            memory can insert wait states. Illegal encodings stop the core
//            in a sticky halt (or act as a nop, selected by parameter).
// Ports    : clk            rising-edge clock
//            reset          asynchronous, active-low reset
//            mem_req        memory access request
//            mem_we         1 = write, 0 = read (valid while mem_req)
//            mem_addr       byte address, low ADDR_W bits (valid while mem_req)
//            mem_wdata      store data (valid while mem_req && mem_we)
//            mem_rdata      read data, sampled when mem_ready = 1
//            mem_ready      access completes this cycle
//            halted         sticky, core stopped in HALT
//            pc             current PC (debug)
//            zero           ALU zero flag of the current cycle
// Options  : MIPS_MC_JAL_EN  when defined, op 0x03 (jal) is executed through
//                            the LINK state; otherwise it is illegal.
// Revision : 1.0  initial release
// ============================================================================
module mips_mc_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned ADDR_W          = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc,
  output logic              zero
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTYPE  = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IMMEX  = 4'd8;
  localparam logic [3:0] S_IMMWB  = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;
`ifdef MIPS_MC_JAL_EN
  localparam logic [3:0] S_LINK   = 4'd13;
  localparam logic [5:0] OP_JAL   = 6'h03;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PCS_ALU    = 2'd0;  // PC + 4 from the ALU
  localparam logic [1:0] PCS_ALUOUT = 2'd1;  // branch target held in ALUOut
  localparam logic [1:0] PCS_JUMP   = 2'd2;  // pseudo-direct jump target

  localparam logic [1:0] RFS_ALUOUT = 2'd0;
  localparam logic [1:0] RFS_MDR    = 2'd1;
  localparam logic [1:0] RFS_PC     = 2'd2;

  // --------------------------------------------------------------------------
  // Architectural and pipeline-ish registers
  // --------------------------------------------------------------------------
  logic [3:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0] rf_q [32];

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, imm_zext, br_off, j_target;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'd0, ir_q[15:0]};
  assign br_off   = {imm_sext[29:0], 2'b00};
  assign j_target = {pc_q[31:28], ir_q[25:0], 2'b00};

  logic [3:0] illegal_next;
  assign illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  logic       funct_ok;
  logic [2:0] funct_alu;
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU and its operand selection
  // --------------------------------------------------------------------------
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;

  always_comb begin
    alu_a  = a_q;
    alu_b  = b_q;
    alu_op = ALU_ADD;
    case (state_q)
      S_FETCH:  begin alu_a = pc_q; alu_b = 32'd4;  end
      S_DECODE: begin alu_a = pc_q; alu_b = br_off; end
      S_MEMADR: alu_b = imm_sext;
      S_RTYPE:  alu_op = funct_alu;
      S_IMMEX: begin
        case (op)
          OP_ANDI: begin alu_b = imm_zext; alu_op = ALU_AND; end
          OP_ORI:  begin alu_b = imm_zext; alu_op = ALU_OR;  end
          default: alu_b = imm_sext;
        endcase
      end
      S_BRANCH: alu_op = ALU_SUB;
      default:  ;
    endcase
  end

  always_comb begin
    alu_y = alu_a + alu_b;
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  assign zero = (alu_y == 32'd0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next state (memory states stall until mem_ready)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:                 state_d = S_RTYPE;
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
`ifdef MIPS_MC_JAL_EN
          OP_JAL:                   state_d = S_LINK;
`endif
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          default:                  state_d = illegal_next;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTYPE:  state_d = funct_ok ? S_RWB : illegal_next;
      S_IMMEX:  state_d = S_IMMWB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;  // MEMWB, RWB, IMMWB, BRANCH, JUMP, LINK
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / datapath strobes
  // --------------------------------------------------------------------------
  logic       req, we, addr_pc, halt_st;
  logic       ir_we, pc_we, ab_we, aluout_we, mdr_we, rf_we;
  logic [1:0] pc_src, rf_src;
  logic [4:0] rf_wa;

  always_comb begin
    req       = 1'b0;
    we        = 1'b0;
    addr_pc   = 1'b0;
    halt_st   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    ab_we     = 1'b0;
    aluout_we = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    pc_src    = PCS_ALU;
    rf_src    = RFS_ALUOUT;
    rf_wa     = rt;
    case (state_q)
      S_FETCH: begin
        req     = 1'b1;
        addr_pc = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      S_DECODE: begin ab_we = 1'b1; aluout_we = 1'b1; end
      S_MEMADR: aluout_we = 1'b1;
      S_MEMRD:  begin req = 1'b1; mdr_we = mem_ready; end
      S_MEMWB:  begin rf_we = 1'b1; rf_src = RFS_MDR; end
      S_MEMWR:  begin req = 1'b1; we = 1'b1; end
      // An illegal funct leaves ALUOut untouched so the nop case has no effect.
      S_RTYPE:  aluout_we = funct_ok;
      S_RWB:    begin rf_we = 1'b1; rf_wa = rd; end
      S_IMMEX:  aluout_we = 1'b1;
      S_IMMWB:  rf_we = 1'b1;
      S_BRANCH: begin
        pc_we  = (op == OP_BNE) ? !zero : zero;
        pc_src = PCS_ALUOUT;
      end
      S_JUMP:   begin pc_we = 1'b1; pc_src = PCS_JUMP; end
`ifdef MIPS_MC_JAL_EN
      // PC already points past the jal, so it is the link address.
      S_LINK: begin
        rf_we  = 1'b1;
        rf_wa  = 5'd31;
        rf_src = RFS_PC;
        pc_we  = 1'b1;
        pc_src = PCS_JUMP;
      end
`endif
      S_HALT:   halt_st = 1'b1;
      default:  ;
    endcase
  end

  // Bus outputs: request is forced low while reset is held, even mid-access.
  assign mem_req   = req & reset;
  assign mem_we    = we & reset;
  assign mem_addr  = addr_pc ? pc_q[ADDR_W-1:0] : aluout_q[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign halted    = halt_st;
  assign pc        = pc_q;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_comb begin
    case (pc_src)
      PCS_ALUOUT: pc_d = aluout_q;
      PCS_JUMP:   pc_d = j_target;
      default:    pc_d = alu_y;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      if (pc_we)     pc_q     <= pc_d;
      if (ir_we)     ir_q     <= mem_rdata;
      if (ab_we)     a_q      <= rf_q[rs];
      if (ab_we)     b_q      <= rf_q[rt];
      if (aluout_we) aluout_q <= alu_y;
      if (mdr_we)    mdr_q    <= mem_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Register file: $0 is never written, so it always reads as zero.
  // --------------------------------------------------------------------------
  logic [31:0] rf_wd;
  always_comb begin
    case (rf_src)
      RFS_MDR: rf_wd = mdr_q;
      RFS_PC:  rf_wd = pc_q;
      default: rf_wd = aluout_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_wa != 5'd0)) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_core
// Purpose  : Self-checking bench for mips_mc_core. A table of single
//            instructions (address, encoding, latency, next fetch address,
//            expected store) is run on a zero-wait memory, followed by
//            hand-written sequences for wait states, illegal-op halt,
//            reset during a stalled fetch and the optional jal.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_mc_core;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        halted;
  logic [31:0] pc;
  logic        zero;

  mips_mc_core dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .pc        (pc),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Memory model: 4 KiB, word addressed. While not ready it returns junk so a
  // premature capture of read data shows up later in a store.
  // --------------------------------------------------------------------------
  logic [31:0] mem [0:1023];
  logic        rdy;
  int          wr_cnt;
  logic [31:0] last_wa, last_wd;

  assign mem_ready = rdy;
  assign mem_rdata = rdy ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset && mem_req && mem_we && mem_ready) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string name, input logic [31:0] addr);
    chk({name, "_req"},  {31'd0, mem_req}, 32'd1);
    chk({name, "_we"},   {31'd0, mem_we},  32'd0);
    chk({name, "_addr"}, mem_addr,         addr);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] nxt;
    int          cyc;
    bit          st;
    logic [31:0] sa;
    logic [31:0] sd;
    bit          cz;
    bit          ez;
  } vec_t;

  vec_t vq[$];

  initial begin
    int w0;
    n_chk  = 0;
    n_fail = 0;
    wr_cnt = 0;
    last_wa = '0;
    last_wd = '0;
    reset = 1'b0;
    rdy   = 1'b1;

    //             pc          instr         next       cyc st addr      data          cz ez
    vq.push_back('{32'h000, 32'h2001_0005, 32'h004, 4, 0, 32'h0,  32'h0,         0, 0}); // addi $1,$0,5
    vq.push_back('{32'h004, 32'h2002_0007, 32'h008, 4, 0, 32'h0,  32'h0,         0, 0}); // addi $2,$0,7
    vq.push_back('{32'h008, 32'h0022_1820, 32'h00C, 4, 0, 32'h0,  32'h0,         0, 0}); // add $3,$1,$2
    vq.push_back('{32'h00C, 32'hAC03_0040, 32'h010, 4, 1, 32'h40, 32'd12,        0, 0}); // sw $3,0x40($0)
    vq.push_back('{32'h010, 32'h3404_FFFF, 32'h014, 4, 0, 32'h0,  32'h0,         0, 0}); // ori $4,$0,0xFFFF
    vq.push_back('{32'h014, 32'h2005_FFFF, 32'h018, 4, 0, 32'h0,  32'h0,         0, 0}); // addi $5,$0,-1
    vq.push_back('{32'h018, 32'h00A4_302A, 32'h01C, 4, 0, 32'h0,  32'h0,         0, 0}); // slt $6,$5,$4
    vq.push_back('{32'h01C, 32'h0084_0020, 32'h020, 4, 0, 32'h0,  32'h0,         0, 0}); // add $0,$4,$4
    vq.push_back('{32'h020, 32'h1021_0003, 32'h030, 3, 0, 32'h0,  32'h0,         1, 1}); // beq $1,$1,+3
    vq.push_back('{32'h030, 32'h1421_0003, 32'h034, 3, 0, 32'h0,  32'h0,         1, 1}); // bne $1,$1,+3
    vq.push_back('{32'h034, 32'h0800_0100, 32'h400, 3, 0, 32'h0,  32'h0,         0, 0}); // j 0x100
    vq.push_back('{32'h400, 32'hAC04_0044, 32'h404, 4, 1, 32'h44, 32'h0000_FFFF, 0, 0}); // sw $4
    vq.push_back('{32'h404, 32'hAC05_0048, 32'h408, 4, 1, 32'h48, 32'hFFFF_FFFF, 0, 0}); // sw $5
    vq.push_back('{32'h408, 32'hAC06_004C, 32'h40C, 4, 1, 32'h4C, 32'd1,         0, 0}); // sw $6
    vq.push_back('{32'h40C, 32'hAC00_0050, 32'h410, 4, 1, 32'h50, 32'd0,         0, 0}); // sw $0
    vq.push_back('{32'h410, 32'h30A7_00F0, 32'h414, 4, 0, 32'h0,  32'h0,         0, 0}); // andi $7,$5,0xF0
    vq.push_back('{32'h414, 32'h0085_4022, 32'h418, 4, 0, 32'h0,  32'h0,         0, 0}); // sub $8,$4,$5
    vq.push_back('{32'h418, 32'h0085_482A, 32'h41C, 4, 0, 32'h0,  32'h0,         0, 0}); // slt $9,$4,$5
    vq.push_back('{32'h41C, 32'h1485_0002, 32'h428, 3, 0, 32'h0,  32'h0,         1, 0}); // bne $4,$5,+2
    vq.push_back('{32'h428, 32'hAC07_0054, 32'h42C, 4, 1, 32'h54, 32'h0000_00F0, 0, 0}); // sw $7
    vq.push_back('{32'h42C, 32'hAC08_0058, 32'h430, 4, 1, 32'h58, 32'h0001_0000, 0, 0}); // sw $8
    vq.push_back('{32'h430, 32'hAC09_005C, 32'h434, 4, 1, 32'h5C, 32'd0,         0, 0}); // sw $9
    vq.push_back('{32'h434, 32'h0022_5025, 32'h438, 4, 0, 32'h0,  32'h0,         0, 0}); // or $10,$1,$2
    vq.push_back('{32'h438, 32'h0022_5824, 32'h43C, 4, 0, 32'h0,  32'h0,         0, 0}); // and $11,$1,$2
    vq.push_back('{32'h43C, 32'hAC0A_0060, 32'h440, 4, 1, 32'h60, 32'd7,         0, 0}); // sw $10
    vq.push_back('{32'h440, 32'hAC0B_0064, 32'h444, 4, 1, 32'h64, 32'd5,         0, 0}); // sw $11

    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    #1;
    for (int i = 0; i < vq.size(); i++) mem[vq[i].pc[11:2]] <= vq[i].instr;
    mem[32'h444 >> 2] <= 32'h8C0C_0040;  // lw $12,0x40($0)
    mem[32'h448 >> 2] <= 32'hAC0C_0068;  // sw $12,0x68($0)
    mem[32'h44C >> 2] <= 32'hFC00_0000;  // illegal op 0x3F
    #1;

    // ---------------- reset state ----------------
    chk("rst_req",    {31'd0, mem_req}, 32'd0);
    chk("rst_halted", {31'd0, halted},  32'd0);
    chk("rst_pc",     pc,               32'h0);
    step();
    chk("rst_req_clk", {31'd0, mem_req}, 32'd0);
    reset = 1'b1;
    #1;
    chk_fetch("first_fetch", vq[0].pc);

    // ---------------- table-driven single instructions ----------------
    for (int i = 0; i < vq.size(); i++) begin
      w0 = wr_cnt;
      repeat (vq[i].cyc - 1) step();
      if (vq[i].cz) chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vq[i].ez});
      step();
      chk_fetch($sformatf("v%0d_next", i), vq[i].nxt);
      chk($sformatf("v%0d_pc", i), pc, vq[i].nxt);
      chk($sformatf("v%0d_wrcnt", i), wr_cnt - w0, vq[i].st ? 32'd1 : 32'd0);
      if (vq[i].st) begin
        chk($sformatf("v%0d_waddr", i), last_wa, vq[i].sa);
        chk($sformatf("v%0d_wdata", i), last_wd, vq[i].sd);
      end
    end

    // ---------------- lw with three wait states ----------------
    step();               // FETCH -> DECODE
    step();               // DECODE -> MEMADR
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin
        rdy = 1'b1;
        #1;
      end
      chk($sformatf("lw_wait%0d_req", k),  {31'd0, mem_req}, 32'd1);
      chk($sformatf("lw_wait%0d_we", k),   {31'd0, mem_we},  32'd0);
      chk($sformatf("lw_wait%0d_addr", k), mem_addr,         32'h40);
      chk($sformatf("lw_wait%0d_pc", k),   pc,               32'h448);
    end
    step();               // MEMRD -> MEMWB
    step();               // MEMWB -> FETCH
    chk_fetch("lw_next", 32'h448);

    w0 = wr_cnt;
    repeat (4) step();
    chk("lw_sw_wrcnt", wr_cnt - w0, 32'd1);
    chk("lw_sw_waddr", last_wa,     32'h68);
    chk("lw_sw_wdata", last_wd,     32'd12);
    chk_fetch("lw_sw_next", 32'h44C);

    // ---------------- illegal opcode halts ----------------
    step();
    step();
    chk("ill_halted", {31'd0, halted},  32'd1);
    chk("ill_req",    {31'd0, mem_req}, 32'd0);
    chk("ill_pc",     pc,               32'h450);
    repeat (3) step();
    chk("ill_halted_hold", {31'd0, halted},  32'd1);
    chk("ill_req_hold",    {31'd0, mem_req}, 32'd0);

    // ---------------- reset from halt, then reset mid-wait ----------------
    reset = 1'b0;
    #1;
    chk("rst2_halted", {31'd0, halted},  32'd0);
    chk("rst2_req",    {31'd0, mem_req}, 32'd0);
    chk("rst2_pc",     pc,               32'h0);
    step();
    reset = 1'b1;
    #1;
    chk_fetch("rst2_fetch0", 32'h0);
    repeat (4) step();
    chk_fetch("rst2_fetch4", 32'h4);
    rdy = 1'b0;
    step();
    step();
    chk_fetch("stall_fetch4", 32'h4);
    chk("stall_pc", pc, 32'h4);
    reset = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_pc",  pc,               32'h0);

    // ---------------- jal (optional feature) ----------------
    mem[0]  <= 32'h0800_0002;  // j 0x08
    mem[2]  <= 32'h0C00_0040;  // jal 0x40 -> target 0x100
    mem[64] <= 32'hAC1F_0070;  // sw $31,0x70($0)
    rdy = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk_fetch("jal_fetch0", 32'h0);
    repeat (3) step();
    chk_fetch("jal_fetch8", 32'h8);
`ifdef MIPS_MC_JAL_EN
    repeat (3) step();
    chk_fetch("jal_target", 32'h100);
    w0 = wr_cnt;
    repeat (4) step();
    chk("jal_wrcnt", wr_cnt - w0, 32'd1);
    chk("jal_waddr", last_wa,     32'h70);
    chk("jal_link",  last_wd,     32'h0C);
    chk_fetch("jal_after", 32'h104);
`else
    step();
    step();
    chk("jal_ill_halted", {31'd0, halted},  32'd1);
    chk("jal_ill_req",    {31'd0, mem_req}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
- Parametrised multicycle MIPS core; next generation of the team's multicycle datapath/control pair.
- Merges datapath and control FSM into one block and adds:
  - an external memory bus with a req/ready handshake, so memory may insert wait states;
  - instructions bne, addi, andi, ori;
  - a sticky halt on illegal encodings.
- Sits between the SoC memory fabric and the debug/test harness.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr; low ADDR_W bits of the internal byte address are driven out.
- HALT_ON_ILLEGAL, 1, 1: illegal op/funct enters HALT; 0: illegal op/funct is treated as nop (back to FETCH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  ADDR_W  byte address; valid while mem_req=1.
- mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  input  32  read data; sampled in the cycle mem_ready=1.
- mem_ready  input  1  access completes this cycle.
- halted  output  1  sticky; core stopped in HALT.
- pc  output  32  current PC (debug).
- zero  output  1  ALU zero flag from the current cycle.

Behaviour:
- Reset (reset=0, asynchronous), effective immediately, including mid-access:
  - PC=RESET_PC, IR=0, A=B=ALUOut=MDR=0, all 32 registers=0.
  - State=FETCH; mem_req is forced to 0 while reset=0; halted=0.
  - First request is issued in the first cycle after reset deasserts.
- Register file: 32x32, two async read ports, one write port; $0 reads 0 and writes to it are ignored.
- ALU: 32-bit; add, sub, and, or, slt (signed); zero = (result==0).
- Immediates:
  - addi and branches sign-extend imm16.
  - andi and ori zero-extend imm16.
  - Branch offset = signext(imm16)<<2.
  - Jump target = {PC[31:28], instr[25:0], 2'b00}.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the cycle mem_ready=1.
  - mem_ready is ignored when mem_req=0.
  - Zero-wait memory (ready in the same cycle) is legal.
  - mem_req drops the cycle after completion unless the next state also requests.
- FSM states and transitions (memory states stall while mem_ready=0):
  - FETCH: req read at PC; on ready, IR<=rdata, PC<=PC+4; ->DECODE.
  - DECODE: A<=rs, B<=rt, ALUOut<=PC+branch offset; dispatch on op:
    - op 0x00 ->RTYPE
    - op 0x23/0x2B ->MEMADR
    - op 0x04/0x05 ->BRANCH
    - op 0x02 ->JUMP
    - op 0x08/0x0C/0x0D ->IMMEX
    - any other op ->ILLEGAL handling
  - MEMADR: ALUOut<=A+signext; lw->MEMRD, sw->MEMWR.
  - MEMRD: req read at ALUOut; on ready, MDR<=rdata; ->MEMWB.
  - MEMWB: rt<=MDR; ->FETCH.
  - MEMWR: req write at ALUOut with wdata=B; on ready ->FETCH.
  - RTYPE: ALUOut<=A op B; funct 0x20/0x22/0x24/0x25/0x2A, else illegal; ->RWB.
  - RWB: rd<=ALUOut; ->FETCH.
  - IMMEX: ALUOut<=A op imm; ->IMMWB.
  - IMMWB: rt<=ALUOut; ->FETCH.
  - BRANCH: compute A-B; beq taken if zero, bne taken if !zero; taken: PC<=ALUOut; ->FETCH.
  - JUMP: PC<=target; ->FETCH.
  - HALT: mem_req=0, halted=1; remain until reset.
- Latency with zero-wait memory, in cycles:
  - R-type 4, lw 5, sw 4, addi/andi/ori 4, branch 3, j 3.
  - Each wait state adds 1 cycle.
- Address and width rules:
  - PC+4 wraps modulo 2^32.
  - Unaligned addresses are driven unchanged; no exception is raised.
- Writeback and illegal handling:
  - Writeback to $0 is suppressed, but the instruction still completes normally.
  - Illegal op/funct with HALT_ON_ILLEGAL=0 produces no architectural side effect other than PC+4.

Optional Feature:
- Macro MIPS_MC_JAL_EN.
- Defined: op 0x03 (jal) is decoded to state LINK, which writes $31<=PC (already PC+4) and PC<=jump target, then ->FETCH; 3 cycles.
- Undefined: op 0x03 is an illegal opcode.

Test Plan:
- Reset, zero-wait memory holding addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x40($0) -> write at addr 0x40 with wdata 12; PC=0x10 after the store; 4+4+4+4 cycles.
- lw with mem_ready held low for 3 cycles -> mem_addr/mem_req stable for all 4 cycles; MDR captures rdata only on the ready cycle; total lw = 8 cycles.
- beq $1,$1,+3 at PC 0x20 -> next fetch at 0x30; bne $1,$1,+3 -> next fetch at 0x24; j 0x100 at 0x40 -> next fetch at 0x400.
- ori $4,$0,0xFFFF -> $4=0x0000FFFF; addi $5,$0,-1 -> $5=0xFFFFFFFF; slt $6,$5,$4 -> 1; add $0,$4,$4 -> $0 still 0.
- Illegal op 0x3F with HALT_ON_ILLEGAL=1 -> halted=1 after DECODE, mem_req=0 thereafter; assert reset mid-wait of a later fetch -> mem_req=0 immediately and PC=RESET_PC.
- With MIPS_MC_JAL_EN: jal 0x40 at PC 0x08 -> $31=0x0C, next fetch 0x100; without the macro, the same instruction halts.
